// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// one-cycle valid and framing-error strobes, held output byte.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_RX_Serial,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_DV,
  output logic       o_RX_Frame_Err,
  output logic       o_RX_Active
);

  localparam int unsigned HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam logic [15:0] HALF_CNT = 16'(HALF_BIT);
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } state_e;

  logic        sync1_q, sync2_q;
  logic        rx_s;
  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [2:0]  index_q, index_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        fe_q, fe_d;
  logic        active_q, active_d;

  // Synchronizer resets high so releasing reset never looks like a start bit.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_RX_Serial;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // Receiver state and datapath registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= 16'd0;
      index_q  <= 3'd0;
      shift_q  <= 8'd0;
      byte_q   <= 8'd0;
      dv_q     <= 1'b0;
      fe_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      index_q  <= index_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      fe_q     <= fe_d;
      active_q <= active_d;
    end
  end

  // Next-state and output logic; strobes default low so each lasts one cycle.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    index_d  = index_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    fe_d     = 1'b0;
    active_d = active_q;

    case (state_q)
      ST_IDLE: begin
        count_d = 16'd0;
        index_d = 3'd0;
        if (!rx_s) begin
          state_d  = ST_START;
          active_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (count_q < HALF_CNT) begin
          count_d = count_q + 16'd1;
        end else if (!rx_s) begin
          state_d = ST_DATA;
          count_d = 16'd0;
        end else begin
          // Low pulse shorter than half a bit: treat as noise.
          state_d  = ST_IDLE;
          count_d  = 16'd0;
          active_d = 1'b0;
        end
      end

      ST_DATA: begin
        if (count_q < LAST_CNT) begin
          count_d = count_q + 16'd1;
        end else begin
          count_d          = 16'd0;
          shift_d[index_q] = rx_s;
          if (index_q < 3'd7) begin
            index_d = index_q + 3'd1;
          end else begin
            index_d = 3'd0;
            state_d = ST_STOP;
          end
        end
      end

      ST_STOP: begin
        if (count_q < LAST_CNT) begin
          count_d = count_q + 16'd1;
        end else begin
          count_d = 16'd0;
          state_d = ST_CLEANUP;
          if (rx_s) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end
      end

      ST_CLEANUP: begin
        // Hold here on a stuck-low line so a break cannot start a new frame.
        if (rx_s) begin
          state_d  = ST_IDLE;
          active_d = 1'b0;
        end else begin
          state_d = ST_CLEANUP;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        count_d  = 16'd0;
        index_d  = 3'd0;
        active_d = 1'b0;
      end
    endcase
  end

  assign o_RX_Byte      = byte_q;
  assign o_RX_DV        = dv_q;
  assign o_RX_Frame_Err = fe_q;
  assign o_RX_Active    = active_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at CLKS_PER_BIT=8; expected strobe
// times come from the frame timing formula, bytes from a transmit-side model.
module tb_uart_receiver;

  localparam int CPB  = 8;
  localparam int HALF = (CPB - 1) / 2;
  // Cycle offset from the negedge that drops the line to the negedge that sees
  // the strobe: t0 is the next posedge, strobe at t0+3+HALF+9*CPB.
  localparam int STROBE_OFS = 1 + 3 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_dv, rx_fe, rx_act;

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;
  int both_cnt = 0;

  typedef struct {int c; logic [7:0] b; bit fe;} ev_t;
  ev_t got_q[$];
  ev_t exp_q[$];
  bit  act_log [0:131071];

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_RX_Serial    (rx),
    .o_RX_Byte      (rx_byte),
    .o_RX_DV        (rx_dv),
    .o_RX_Frame_Err (rx_fe),
    .o_RX_Active    (rx_act)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    act_log[cyc] <= rx_act;
    if (rx_dv && rx_fe) both_cnt <= both_cnt + 1;
    if (rx_dv || rx_fe) got_q.push_back('{cyc, rx_byte, rx_fe});
  end

  task automatic send_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int stop_len,
                            input logic stop_val, output int t_drop);
    t_drop = cyc;
    send_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) send_bit(d[i], CPB);
    send_bit(stop_val, stop_len);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (rx_byte !== 8'h00) begin tests_failed++; $display("FAIL reset_byte: got %h want 00", rx_byte); end
    tests_run++;
    if ({rx_dv, rx_fe, rx_act} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b want 000", {rx_dv, rx_fe, rx_act}); end
    rst_n = 1'b1;
    got_q.delete();
    repeat (20) @(negedge clk);
    tests_run++;
    if (got_q.size() != 0 || rx_act !== 1'b0) begin
      tests_failed++; $display("FAIL reset_release: events %0d active %b want 0 0", got_q.size(), rx_act);
    end
  endtask

  task automatic test_single();
    int t, bad;
    got_q.delete();
    send_frame(8'hA5, CPB, 1'b1, t);
    send_bit(1'b1, 10);
    tests_run++;
    if (got_q.size() != 1) begin
      tests_failed++; $display("FAIL single_count: got %0d want 1", got_q.size());
    end else begin
      tests_run++;
      if (got_q[0].c != t + STROBE_OFS || got_q[0].fe || got_q[0].b !== 8'hA5) begin
        tests_failed++;
        $display("FAIL single_dv: cyc %0d fe %b byte %h want cyc %0d fe 0 byte a5",
                 got_q[0].c - t, got_q[0].fe, got_q[0].b, STROBE_OFS);
      end
    end
    tests_run++;
    if (rx_byte !== 8'hA5) begin tests_failed++; $display("FAIL single_hold: got %h want a5", rx_byte); end
    bad = 0;
    for (int c = t + 3; c <= t + STROBE_OFS; c++) if (!act_log[c]) bad++;
    tests_run++;
    if (bad != 0 || act_log[t + 2] || act_log[t + STROBE_OFS + 1]) begin
      tests_failed++;
      $display("FAIL single_active: low-in-window %0d before %b after %b want 0 0 0",
               bad, act_log[t + 2], act_log[t + STROBE_OFS + 1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [3];
    int t [3];
    d[0] = 8'h00; d[1] = 8'hFF; d[2] = 8'h3C;
    got_q.delete();
    for (int i = 0; i < 3; i++) send_frame(d[i], CPB, 1'b1, t[i]);
    send_bit(1'b1, 10);
    tests_run++;
    if (got_q.size() != 3) begin
      tests_failed++; $display("FAIL b2b_count: got %0d want 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (got_q[i].c != t[0] + STROBE_OFS + 80 * i || got_q[i].fe || got_q[i].b !== d[i]) begin
          tests_failed++;
          $display("FAIL b2b_frame%0d: cyc %0d byte %h fe %b want cyc %0d byte %h fe 0",
                   i, got_q[i].c - t[0], got_q[i].b, got_q[i].fe, STROBE_OFS + 80 * i, d[i]);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int t;
    got_q.delete();
    t = cyc;
    send_bit(1'b0, 3);
    send_bit(1'b1, 30);
    tests_run++;
    if (got_q.size() != 0 || rx_byte !== 8'h3C) begin
      tests_failed++; $display("FAIL glitch_quiet: events %0d byte %h want 0 3c", got_q.size(), rx_byte);
    end
    tests_run++;
    if (act_log[t + 3] !== 1'b1 || act_log[t + 3 + HALF + 1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_active: start %b after %b want 1 0", act_log[t + 3], act_log[t + 3 + HALF + 1]);
    end
  endtask

  task automatic test_frame_err();
    int t;
    got_q.delete();
    send_frame(8'h55, 40, 1'b0, t);
    send_bit(1'b1, 100);
    tests_run++;
    if (got_q.size() != 1) begin
      tests_failed++; $display("FAIL ferr_count: got %0d want 1", got_q.size());
    end else begin
      tests_run++;
      if (!got_q[0].fe || got_q[0].c != t + STROBE_OFS) begin
        tests_failed++; $display("FAIL ferr_pulse: fe %b cyc %0d want 1 %0d", got_q[0].fe, got_q[0].c - t, STROBE_OFS);
      end
    end
    tests_run++;
    if (rx_byte !== 8'h3C) begin tests_failed++; $display("FAIL ferr_hold: got %h want 3c", rx_byte); end
    // Line returns high at t+72+40; two sync flops plus one FSM edge later.
    tests_run++;
    if (act_log[t + 114] !== 1'b1 || act_log[t + 115] !== 1'b0) begin
      tests_failed++; $display("FAIL ferr_active: %b%b want 10", act_log[t + 114], act_log[t + 115]);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int t;
    d = 8'h81;
    got_q.delete();
    send_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) send_bit(d[i], CPB);
    send_bit(d[4], 3);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if ({rx_byte, rx_dv, rx_fe, rx_act} !== 11'd0) begin
      tests_failed++; $display("FAIL midrst_outputs: byte %h flags %b want 00 000", rx_byte, {rx_dv, rx_fe, rx_act});
    end
    rst_n = 1'b1;
    send_bit(1'b1, 20);
    tests_run++;
    if (got_q.size() != 0) begin tests_failed++; $display("FAIL midrst_abort: events %0d want 0", got_q.size()); end
    send_frame(8'h42, CPB, 1'b1, t);
    send_bit(1'b1, 10);
    tests_run++;
    if (got_q.size() != 1 || got_q[0].b !== 8'h42 || got_q[0].fe || got_q[0].c != t + STROBE_OFS) begin
      tests_failed++;
      $display("FAIL midrst_next: events %0d byte %h want 1 42", got_q.size(), rx_byte);
    end
  endtask

  task automatic test_random();
    logic [7:0] last_good, d;
    bit bad, prev_bad;
    int t, gap;
    last_good = 8'h42;
    prev_bad  = 1'b0;
    got_q.delete();
    exp_q.delete();
    for (int n = 0; n < 40; n++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      gap = $urandom_range(prev_bad ? 1 : 0, 15);
      if (gap > 0) send_bit(1'b1, gap);
      send_frame(d, CPB, bad ? 1'b0 : 1'b1, t);
      if (!bad) last_good = d;
      exp_q.push_back('{t + STROBE_OFS, last_good, bad});
      prev_bad = bad;
    end
    send_bit(1'b1, 20);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (got_q[i].c != exp_q[i].c || got_q[i].b !== exp_q[i].b || got_q[i].fe != exp_q[i].fe) begin
          tests_failed++;
          $display("FAIL rand_frame%0d: cyc %0d byte %h fe %b want cyc %0d byte %h fe %b", i,
                   got_q[i].c, got_q[i].b, got_q[i].fe, exp_q[i].c, exp_q[i].b, exp_q[i].fe);
        end
      end
    end
    tests_run++;
    if (rx_byte !== last_good || both_cnt != 0) begin
      tests_failed++; $display("FAIL rand_final: byte %h both %0d want %h 0", rx_byte, both_cnt, last_good);
    end
  endtask

  task automatic test_loopback();
    int t, fe_cnt;
    got_q.delete();
    exp_q.delete();
    for (int v = 0; v < 256; v++) begin
      send_frame(8'(v), CPB, 1'b1, t);
      exp_q.push_back('{t + STROBE_OFS, 8'(v), 1'b0});
      send_bit(1'b1, 1);
    end
    send_bit(1'b1, 20);
    fe_cnt = 0;
    foreach (got_q[i]) if (got_q[i].fe) fe_cnt++;
    tests_run++;
    if (got_q.size() != 256 || fe_cnt != 0) begin
      tests_failed++; $display("FAIL loop_count: got %0d frames %0d errors want 256 0", got_q.size(), fe_cnt);
    end else begin
      for (int i = 0; i < 256; i++) begin
        tests_run++;
        if (got_q[i].b !== exp_q[i].b || got_q[i].c != exp_q[i].c) begin
          tests_failed++;
          $display("FAIL loop_byte%0d: got %h at %0d want %h at %0d", i, got_q[i].b, got_q[i].c, exp_q[i].b, exp_q[i].c);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_random();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8N1 UART receive block: one start bit, eight data bits LSB first, one stop bit, no parity.
- Line idles high.
- Samples the asynchronous serial input at mid-bit.
- Presents each received byte with a one-cycle valid strobe and flags framing errors.
- Consumes the serial stream produced by the UART transmitter on the far end; loops back to our transmitter in the loopback bench.

Parameters:
- CLKS_PER_BIT, 87, i_clock cycles per bit = f(i_clock)/baud. Legal range 4..65535.
- HALF_BIT, derived, (CLKS_PER_BIT-1)/2 with integer division. Not user-settable.

Ports:
- i_clock  in  1  system clock, all logic on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_RX_Serial  in  1  asynchronous serial line, idle high.
- o_RX_Byte  out  8  last correctly framed byte; held until the next good byte.
- o_RX_DV  out  1  one-cycle pulse; o_RX_Byte updated this cycle.
- o_RX_Frame_Err  out  1  one-cycle pulse; stop bit sampled low, byte discarded.
- o_RX_Active  out  1  high while a frame is being received.

Behaviour:
- Reset, asynchronous, active-low:
  - o_RX_Byte=0, o_RX_DV=0, o_RX_Frame_Err=0, o_RX_Active=0.
  - State=IDLE, counters=0.
  - Both synchronizer flops=1, so deassertion never fakes a start bit.
- Reset mid-frame aborts the frame silently: no DV, no error.
- Synchronizer: two flops on i_RX_Serial; the FSM sees only rx_s, the second flop output. Pin-to-FSM latency is 2 cycles.
- Bit counter: 16 bits. Bit index: 3 bits. Shift register: 8 bits.
- States: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE:
    - count=0, index=0.
    - rx_s==0 -> START, o_RX_Active<=1.
  - START:
    - While count<HALF_BIT: count++.
    - Else, rx_s==0 -> DATA, count=0.
    - Else, rx_s==1 (glitch shorter than half a bit) -> IDLE, o_RX_Active<=0, no strobe.
  - DATA:
    - While count<CLKS_PER_BIT-1: count++.
    - Else: shift[index]<=rx_s, count=0.
    - index<7 -> index++ and stay in DATA; index==7 -> index=0, go to STOP.
  - STOP:
    - While count<CLKS_PER_BIT-1: count++.
    - Else, rx_s==1 -> o_RX_Byte<=shift, o_RX_DV<=1.
    - Else, rx_s==0 -> o_RX_Frame_Err<=1; o_RX_Byte unchanged.
    - Either way -> CLEANUP, count=0.
  - CLEANUP:
    - o_RX_DV and o_RX_Frame_Err return to 0, so each is exactly one cycle.
    - Stay while rx_s==0 (break/stuck-low line must not retrigger a start).
    - rx_s==1 -> IDLE, o_RX_Active<=0.
  - Illegal state -> IDLE.
- Timing: let t0 be the first rising edge sampling the pin low.
  - START entered at t0+2.
  - Data bit k (k=0..7) sampled at t0+3+HALF_BIT+(k+1)*CLKS_PER_BIT.
  - Stop bit sampled, and DV/Frame_Err registered, at t0+3+HALF_BIT+9*CLKS_PER_BIT.
  - Example, CLKS_PER_BIT=8 (HALF_BIT=3): DV at t0+78.
- Back-to-back frames:
  - A start bit may begin immediately after the stop bit.
  - CLEANUP costs 1 cycle and the stop sample is at mid-bit, so the next start edge is never missed.
- o_RX_DV and o_RX_Frame_Err never assert in the same cycle.

Test Plan:
- CLKS_PER_BIT=8; reset, drive frame for 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> single o_RX_DV pulse at t0+78, o_RX_Byte=0xA5, o_RX_Frame_Err=0, o_RX_Active high t0+2..t0+79.
- Back-to-back 0x00, 0xFF, 0x3C with no idle gap -> three DV pulses spaced 80 cycles apart, bytes 0x00, 0xFF, 0x3C in order.
- Low glitch of 3 cycles on idle line -> START entered, return to IDLE, no DV/Frame_Err, o_RX_Byte unchanged.
- Frame 0x55 with stop bit held 0 for 40 cycles then released -> Frame_Err pulse at stop sample, no DV, o_RX_Byte keeps prior value, o_RX_Active stays high until line high, no spurious second frame.
- Assert i_reset_n low during data bit 4 of 0x81, release while line idle high, then send 0x42 -> no output for aborted frame, outputs 0 during reset, DV with 0x42 afterward.
- Loopback: our UART transmitter (same CLKS_PER_BIT=8) sends 256 bytes 0x00..0xFF -> 256 DV pulses, every byte matches, zero framing errors.
